// File: rtl/cam_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Definitions shared by the camera capture sequencer and the VRAM writer and
// reader:
//   - command mode encodings
//   - capture FSM state encoding
//   - default capture window geometry and watchdog period
//   - decode_mode(): maps a raw 2-bit command onto a mode (reserved -> stop)
// ---------------------------------------------------------------------------
package cam_pkg;

  localparam int CNT_W = 12;

  // Default capture window. Line and byte counts are in camera units; each
  // pixel is 2 bytes, so a line window spans 2*VRAM_H bytes.
  localparam int V_START_DEF   = 12'h080;
  localparam int H_START_P_DEF = 12'h200;
  localparam int VRAM_V_DEF    = 128;
  localparam int VRAM_H_DEF    = 128;
  localparam int WDOG_DEF      = 1 << 20;

  typedef enum logic [1:0] {
    MODE_STOP   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_CONT   = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARM     = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  // The reserved encoding 2'b11 behaves exactly like stop.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_SINGLE;
      2'b10:   return MODE_CONT;
      default: return MODE_STOP;
    endcase
  endfunction

endpackage

// File: rtl/cam_sync_cnt.sv
// ---------------------------------------------------------------------------
// cam_sync_cnt
// Camera timing front end: double-registers vsync/href, detects the vsync
// rising edge and the end of each line, and keeps saturating byte (h) and
// line (v) counters. The VRAM writer reuses this block unchanged.
// Ports:
//   pclk, rstb     camera pixel clock, async active-low reset
//   i_vsync        camera vsync (pclk-synchronous)
//   i_href         camera line valid (pclk-synchronous)
//   o_vs_rise      vsync rising edge seen at the second register stage
//   o_line_end     href falling edge seen at the second register stage
//   o_h_cnt        byte count in the current line
//   o_v_cnt        line count in the current frame
// ---------------------------------------------------------------------------
module cam_sync_cnt
  import cam_pkg::*;
(
  input  logic             pclk,
  input  logic             rstb,
  input  logic             i_vsync,
  input  logic             i_href,
  output logic             o_vs_rise,
  output logic             o_line_end,
  output logic [CNT_W-1:0] o_h_cnt,
  output logic [CNT_W-1:0] o_v_cnt
);

  logic             r_vs_d1, r_vs_d2;
  logic             r_href_d1, r_href_d2;
  logic [CNT_W-1:0] r_h_cnt, r_v_cnt;
  logic             w_vs_rise, w_line_end;

  assign w_vs_rise  = r_vs_d1 & ~r_vs_d2;
  assign w_line_end = ~r_href_d1 & r_href_d2;

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      r_vs_d1   <= 1'b0;
      r_vs_d2   <= 1'b0;
      r_href_d1 <= 1'b0;
      r_href_d2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so d2 takes the pre-edge d1 value and
      // the pair forms a real two-stage shift.
      r_vs_d1   <= i_vsync;
      r_vs_d2   <= r_vs_d1;
      r_href_d1 <= i_href;
      r_href_d2 <= r_href_d1;
    end
  end

  // vsync takes priority over a coincident line end: a new frame always
  // starts from zero.
  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_vs_rise) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_line_end) begin
      r_h_cnt <= '0;
      if (r_v_cnt != '1) r_v_cnt <= r_v_cnt + 1'b1;
    end else if (r_href_d1) begin
      if (r_h_cnt != '1) r_h_cnt <= r_h_cnt + 1'b1;
    end
  end

  assign o_vs_rise  = w_vs_rise;
  assign o_line_end = w_line_end;
  assign o_h_cnt    = r_h_cnt;
  assign o_v_cnt    = r_v_cnt;

endmodule

// File: rtl/cam_cap_ctrl.sv
// ---------------------------------------------------------------------------
// cam_cap_ctrl
// Capture sequencer for the camera-to-VRAM write path. Accepts start/stop
// commands over a 4-phase req/ack handshake, arms on the next vsync, gates
// the VRAM writer with cap_en over the programmable window, and reports
// frame completion, short frames and watchdog timeouts.
// Ports:
//   pclk, rstb        camera pixel clock, async active-low reset
//   c_vsync, href     camera frame / line timing
//   cmd_req, cmd_mode command request level and mode (00 stop, 01 single,
//                     10 continuous, 11 = stop)
//   cmd_ack           command acknowledge level
//   busy              armed or capturing
//   cap_en            current byte is inside the window of an active frame
//   h_cnt, v_cnt      byte / line counters
//   frame_done        one-cycle pulse per completed window
//   frame_cnt         completed frames (wraps)
//   err_short         sticky: vsync arrived before the window completed
//   err_tmo           sticky: no vsync within WDOG cycles while busy
// ---------------------------------------------------------------------------
module cam_cap_ctrl
  import cam_pkg::*;
#(
  parameter int V_START   = V_START_DEF,
  parameter int H_START_P = H_START_P_DEF,
  parameter int VRAM_V    = VRAM_V_DEF,
  parameter int VRAM_H    = VRAM_H_DEF,
  parameter int WDOG      = WDOG_DEF
) (
  input  logic             pclk,
  input  logic             rstb,
  input  logic             c_vsync,
  input  logic             href,
  input  logic             cmd_req,
  input  logic [1:0]       cmd_mode,
  output logic             cmd_ack,
  output logic             busy,
  output logic             cap_en,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             frame_done,
  output logic [7:0]       frame_cnt,
  output logic             err_short,
  output logic             err_tmo
);

  localparam logic [CNT_W-1:0] V_LO = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] V_HI = CNT_W'(V_START + VRAM_V - 1);
  localparam logic [CNT_W-1:0] H_LO = CNT_W'(H_START_P);
  localparam logic [CNT_W-1:0] H_HI = CNT_W'(H_START_P + 2 * VRAM_H - 1);
  localparam int               WD_W = $clog2(WDOG);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(WDOG - 1);

  state_e           r_state, w_state_nxt;
  mode_e            r_mode, w_cmd_mode, w_mode_eff;
  logic             r_cmd_ack;
  logic [WD_W-1:0]  r_wdog;
  logic [7:0]       r_frame_cnt;
  logic             r_err_short, r_err_tmo;

  logic             w_vs_rise, w_line_end;
  logic [CNT_W-1:0] w_h_cnt, w_v_cnt;
  logic             w_busy, w_in_win, w_cmd_acc, w_start_cmd;
  logic             w_wd_exp, w_set_short;

  cam_sync_cnt u_sync (
    .pclk       (pclk),
    .rstb       (rstb),
    .i_vsync    (c_vsync),
    .i_href     (href),
    .o_vs_rise  (w_vs_rise),
    .o_line_end (w_line_end),
    .o_h_cnt    (w_h_cnt),
    .o_v_cnt    (w_v_cnt)
  );

  // A command is taken only on the cycle req is seen while ack is still low;
  // ack then rises, so each request is accepted exactly once.
  assign w_cmd_acc   = cmd_req & ~r_cmd_ack;
  assign w_cmd_mode  = decode_mode(cmd_mode);
  assign w_start_cmd = w_cmd_acc & (w_cmd_mode != MODE_STOP);
  // Mode as seen this cycle, so a command landing on DONE is honoured.
  assign w_mode_eff  = w_cmd_acc ? w_cmd_mode : r_mode;

  assign w_busy   = (r_state == ST_ARM) || (r_state == ST_CAPTURE);
  assign w_in_win = (w_v_cnt >= V_LO) && (w_v_cnt <= V_HI) &&
                    (w_h_cnt >= H_LO) && (w_h_cnt <= H_HI);
  assign w_wd_exp = w_busy && !w_vs_rise && (r_wdog == WD_LAST);

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can leave one
    // unassigned and infer a latch.
    w_state_nxt = r_state;
    w_set_short = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_cmd) w_state_nxt = ST_ARM;
      end
      ST_ARM: begin
        if (w_wd_exp)                                    w_state_nxt = ST_IDLE;
        else if (w_cmd_acc && w_cmd_mode == MODE_STOP)   w_state_nxt = ST_IDLE;
        else if (w_vs_rise)                              w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        // Commands never abandon a frame here; they only change what DONE
        // does next. A vsync mid-window restarts the frame in place.
        if (w_wd_exp)                          w_state_nxt = ST_IDLE;
        else if (w_vs_rise)                    w_set_short = 1'b1;
        else if (w_line_end && w_v_cnt == V_HI) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = (w_mode_eff == MODE_CONT) ? ST_ARM : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rstb) begin
    if (!rstb) begin
      r_cmd_ack   <= 1'b0;
      r_mode      <= MODE_STOP;
      r_wdog      <= '0;
      r_frame_cnt <= '0;
      r_err_short <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      if (w_cmd_acc) begin
        r_cmd_ack <= 1'b1;
        r_mode    <= w_cmd_mode;
      end else if (r_cmd_ack && !cmd_req) begin
        r_cmd_ack <= 1'b0;
      end

      if (!w_busy || w_vs_rise || w_wd_exp) r_wdog <= '0;
      else                                  r_wdog <= r_wdog + 1'b1;

      if (r_state == ST_DONE) r_frame_cnt <= r_frame_cnt + 1'b1;

      // A new error in the same cycle as a clearing command is kept.
      if (w_start_cmd) begin
        r_err_short <= 1'b0;
        r_err_tmo   <= 1'b0;
      end
      if (w_set_short) r_err_short <= 1'b1;
      if (w_wd_exp)    r_err_tmo   <= 1'b1;
    end
  end

  assign cmd_ack    = r_cmd_ack;
  assign busy       = w_busy;
  assign cap_en     = (r_state == ST_CAPTURE) && w_in_win;
  assign h_cnt      = w_h_cnt;
  assign v_cnt      = w_v_cnt;
  assign frame_done = (r_state == ST_DONE);
  assign frame_cnt  = r_frame_cnt;
  assign err_short  = r_err_short;
  assign err_tmo    = r_err_tmo;

endmodule

// File: tb/tb_cam_cap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_cap_ctrl
// Directed bench for cam_cap_ctrl with a reduced window (lines 4..6, bytes
// 6..9, i.e. 12 captured bytes per frame) and a 1000-cycle watchdog, so
// every scenario fits in a few thousand cycles. Frames are 8 lines of 12
// bytes unless stated otherwise.
// ---------------------------------------------------------------------------
module tb_cam_cap_ctrl;

  localparam int TB_V_START = 4;
  localparam int TB_H_START = 6;
  localparam int TB_VRAM_V  = 3;
  localparam int TB_VRAM_H  = 2;
  localparam int TB_WDOG    = 1000;
  localparam int CAP_PER_FRAME = TB_VRAM_V * 2 * TB_VRAM_H;  // 12

  logic        pclk = 1'b0;
  logic        rstb;
  logic        c_vsync, href, cmd_req;
  logic [1:0]  cmd_mode;
  logic        cmd_ack, busy, cap_en, frame_done, err_short, err_tmo;
  logic [11:0] h_cnt, v_cnt;
  logic [7:0]  frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Event counters owned by the monitor; the stimulus only reads them.
  int          n_done = 0;
  int          n_cap  = 0;
  logic [11:0] last_cap_h = '0;
  logic [11:0] last_cap_v = '0;

  int done0, cap0;

  cam_cap_ctrl #(
    .V_START   (TB_V_START),
    .H_START_P (TB_H_START),
    .VRAM_V    (TB_VRAM_V),
    .VRAM_H    (TB_VRAM_H),
    .WDOG      (TB_WDOG)
  ) dut (
    .pclk       (pclk),
    .rstb       (rstb),
    .c_vsync    (c_vsync),
    .href       (href),
    .cmd_req    (cmd_req),
    .cmd_mode   (cmd_mode),
    .cmd_ack    (cmd_ack),
    .busy       (busy),
    .cap_en     (cap_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .err_short  (err_short),
    .err_tmo    (err_tmo)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (frame_done === 1'b1) n_done++;
    if (cap_en === 1'b1) begin
      n_cap++;
      last_cap_h = h_cnt;
      last_cap_v = v_cnt;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: observed no finish, required finish within 2ms");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // One camera frame: vsync pulse, short blank, then lines of href.
  task automatic gen_frame(input int lines, input int bytes);
    @(negedge pclk);
    c_vsync = 1'b1;
    idle(3);
    c_vsync = 1'b0;
    idle(4);
    for (int l = 0; l < lines; l++) begin
      href = 1'b1;
      idle(bytes);
      href = 1'b0;
      idle(4);
    end
  endtask

  // Full 4-phase handshake with bounded waits on both ack edges.
  task automatic send_cmd(input logic [1:0] m, input string tag);
    @(negedge pclk);
    cmd_mode = m;
    cmd_req  = 1'b1;
    @(negedge pclk);
    for (int i = 0; i < 8 && cmd_ack !== 1'b1; i++) @(negedge pclk);
    check({tag, "_ack_hi"}, cmd_ack, 1'b1);
    cmd_req = 1'b0;
    @(negedge pclk);
    for (int i = 0; i < 8 && cmd_ack !== 1'b0; i++) @(negedge pclk);
    check({tag, "_ack_lo"}, cmd_ack, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"},   cmd_ack,    1'b0);
    check({tag, "_busy"},  busy,       1'b0);
    check({tag, "_cap"},   cap_en,     1'b0);
    check({tag, "_h"},     h_cnt,      12'd0);
    check({tag, "_v"},     v_cnt,      12'd0);
    check({tag, "_done"},  frame_done, 1'b0);
    check({tag, "_fcnt"},  frame_cnt,  8'd0);
    check({tag, "_short"}, err_short,  1'b0);
    check({tag, "_tmo"},   err_tmo,    1'b0);
  endtask

  initial begin
    rstb     = 1'b0;
    c_vsync  = 1'b0;
    href     = 1'b0;
    cmd_req  = 1'b0;
    cmd_mode = 2'b00;

    // Reset values
    idle(3);
    check_reset_vals("rst");
    rstb = 1'b1;
    idle(2);

    // Handshake: req held 10 cycles; a mode change while ack is high does
    // nothing (the stop command is the one that was taken).
    @(negedge pclk);
    cmd_mode = 2'b00;
    cmd_req  = 1'b1;
    @(negedge pclk);
    check("hs_ack_cycle1", cmd_ack, 1'b1);
    cmd_mode = 2'b01;
    idle(9);
    check("hs_ack_held", cmd_ack, 1'b1);
    check("hs_second_ignored", busy, 1'b0);
    cmd_req = 1'b0;
    @(negedge pclk);
    check("hs_ack_fall", cmd_ack, 1'b0);
    idle(2);
    check("hs_still_idle", busy, 1'b0);

    // Single shot over 3 frames
    done0 = n_done;
    cap0  = n_cap;
    send_cmd(2'b01, "single");
    check("single_armed", busy, 1'b1);
    gen_frame(8, 12);
    idle(2);
    check("single_busy_after_done", busy, 1'b0);
    check("single_v_cnt", v_cnt, 12'd8);
    check("single_h_cnt", h_cnt, 12'd0);
    check("single_last_cap_h", last_cap_h, 12'd9);
    check("single_last_cap_v", last_cap_v, 12'd6);
    gen_frame(8, 12);
    gen_frame(8, 12);
    idle(2);
    check("single_done_cnt", n_done - done0, 1);
    check("single_cap_cnt", n_cap - cap0, CAP_PER_FRAME);
    check("single_frame_cnt", frame_cnt, 8'd1);

    // Continuous, stop issued mid frame 3
    done0 = n_done;
    cap0  = n_cap;
    send_cmd(2'b10, "cont");
    gen_frame(8, 12);
    check("cont_rearm", busy, 1'b1);
    gen_frame(8, 12);
    fork
      gen_frame(8, 12);
      begin
        idle(40);
        send_cmd(2'b00, "stop");
        check("stop_deferred_busy", busy, 1'b1);
      end
    join
    gen_frame(8, 12);
    idle(2);
    check("cont_done_cnt", n_done - done0, 3);
    check("cont_cap_cnt", n_cap - cap0, 3 * CAP_PER_FRAME);
    check("cont_frame_cnt", frame_cnt, 8'd4);
    check("cont_idle", busy, 1'b0);

    // Short frame: 5 lines never reach window line 6
    done0 = n_done;
    cap0  = n_cap;
    send_cmd(2'b01, "short");
    gen_frame(5, 12);
    check("short_no_err_yet", err_short, 1'b0);
    check("short_no_done", n_done - done0, 0);
    gen_frame(8, 12);
    idle(2);
    check("short_err", err_short, 1'b1);
    check("short_done_next", n_done - done0, 1);
    check("short_cap_cnt", n_cap - cap0, 4 + CAP_PER_FRAME);
    check("short_frame_cnt", frame_cnt, 8'd5);

    // Watchdog: arm with vsync held low
    @(negedge pclk);
    cmd_mode = 2'b01;
    cmd_req  = 1'b1;
    @(negedge pclk);
    check("wd_ack", cmd_ack, 1'b1);
    check("wd_short_cleared", err_short, 1'b0);
    cmd_req = 1'b0;
    idle(999);
    check("wd_busy_999", busy, 1'b1);
    check("wd_tmo_999", err_tmo, 1'b0);
    @(negedge pclk);
    check("wd_busy_1000", busy, 1'b0);
    check("wd_tmo_1000", err_tmo, 1'b1);
    idle(2);

    // Reset in the middle of the window
    send_cmd(2'b01, "rstw");
    check("rstw_tmo_cleared", err_tmo, 1'b0);
    fork
      gen_frame(8, 12);
      begin
        for (int i = 0; i < 400 && cap_en !== 1'b1; i++) @(negedge pclk);
        check("rstw_cap_seen", cap_en, 1'b1);
        idle(1);
        rstb = 1'b0;
        #1;
        check_reset_vals("rstw");
        @(negedge pclk);
        rstb = 1'b1;
      end
    join
    done0 = n_done;
    cap0  = n_cap;
    gen_frame(8, 12);
    idle(2);
    check("post_rst_no_done", n_done - done0, 0);
    check("post_rst_no_cap", n_cap - cap0, 0);
    check("post_rst_idle", busy, 1'b0);
    check("post_rst_v_cnt", v_cnt, 12'd8);
    check("post_rst_fcnt", frame_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_cap_ctrl.md
# cam_cap_ctrl

Capture sequencer for the camera-to-VRAM write path, clocked by the camera pixel clock. Decodes camera frame/line timing and accepts start/stop commands through a 4-phase handshake. Gates the VRAM writer with a per-frame capture enable over a programmable window, and reports frame completion, short frames and loss of camera sync. Sits between the camera pins and the VRAM write-side logic, so that single-shot (freeze) and continuous capture share one window definition.

## Interface
- V_START, 12'h080, first captured line (input line count)
- H_START_P, 12'h200, first captured byte in a line (2 bytes/pixel)
- VRAM_V, 128, captured lines per frame (1..128)
- VRAM_H, 128, captured pixels per line (1..128)
- WDOG, 2^20, pclk cycles without vsync rising edge before timeout
- pclk  in  1  camera pixel clock, all logic on posedge
- rstb  in  1  reset, asynchronous, active-low
- c_vsync  in  1  camera vsync, pclk-synchronous
- href  in  1  camera line valid, pclk-synchronous
- cmd_req  in  1  command request level (already in pclk domain)
- cmd_mode  in  2  00 stop, 01 single, 10 continuous, 11 reserved (treated as stop)
- cmd_ack  out  1  command acknowledge level
- busy  out  1  state is ARM or CAPTURE
- cap_en  out  1  current byte is inside window of an active frame; writer ANDs with its own phase decode
- h_cnt  out  12  byte count in current line
- v_cnt  out  12  line count in current frame
- frame_done  out  1  one-cycle pulse, full window captured
- frame_cnt  out  8  completed frames, wraps 255->0
- err_short  out  1  sticky; vsync arrived before window complete
- err_tmo  out  1  sticky; watchdog expired

## Operation
- Inputs registered twice (d1, d2). vs_rise = d1 & ~d2 on c_vsync. line_end = ~d1 & d2 on href.
- Counters: vs_rise clears h_cnt and v_cnt. line_end increments v_cnt and clears h_cnt. Otherwise href_d1=1 increments h_cnt. Both saturate at 12'hFFF.
- in_win: v_cnt in [V_START, V_START+VRAM_V-1] and h_cnt in [H_START_P, H_START_P+2*VRAM_H-1].
- Handshake: when cmd_req=1 and cmd_ack=0, latch cmd_mode and set cmd_ack=1 next cycle. cmd_ack holds until cmd_req=0, then clears next cycle. cmd_req rising while cmd_ack=1 is ignored.
- FSM states: IDLE, ARM, CAPTURE, DONE.
  - IDLE: latched single or continuous -> ARM.
  - ARM: waits for vs_rise, then -> CAPTURE. A stop command -> IDLE.
  - CAPTURE: cap_en = in_win. line_end on the last window line (v_cnt = V_START+VRAM_V-1) -> DONE. vs_rise before that sets err_short, stays in CAPTURE and restarts the frame.
  - DONE (1 cycle): frame_done=1, frame_cnt++. Goes to ARM if mode is continuous, else IDLE.
- A stop command during CAPTURE is deferred: the frame completes, then DONE -> IDLE. No partial frames are ever abandoned by command.
- A new single command during CAPTURE in continuous mode changes the mode. The current frame is the last.
- Watchdog counter runs in ARM and CAPTURE and clears on vs_rise. Expiry sets err_tmo and -> IDLE. err_short and err_tmo clear only on an accepted single or continuous command.

## Timing
- Reset values: cmd_ack 0, busy 0, cap_en 0, h_cnt 0, v_cnt 0, frame_done 0, frame_cnt 0, err_short 0, err_tmo 0. FSM resets to IDLE.
- cap_en is combinational from registered state and counters, aligned with h_cnt/v_cnt in the same cycle.
- vs_rise is detected 2 cycles after the c_vsync edge. CAPTURE is entered 1 cycle later.
- cmd_ack rises 1 cycle after cmd_req is sampled high and falls 1 cycle after cmd_req is sampled low.
- frame_done occurs 1 cycle after the qualifying line_end.
- vs_rise and line_end in the same cycle: vs_rise wins and counters clear.
- Reset mid-frame forces IDLE immediately with cap_en=0.

## Structure
- Shared package cam_pkg holds:
  - mode encodings (MODE_STOP/SINGLE/CONT)
  - FSM state encoding
  - default window constants, shared with the VRAM writer and reader
- Sub-module cam_sync_cnt holds the input registers, edge detect and h/v counters. The writer reuses it.
- Top level holds the FSM, handshake, watchdog and status.

## Test plan
- Single shot: 3 frames of 640 lines/1280 bytes, command 01 before frame 1 -> exactly one frame_done, frame_cnt=1, busy low after DONE. cap_en high for 128×256 bytes total.
- Continuous then stop: command 10, stop issued mid frame 3 -> frame_done for frames 1–3, none for frame 4, state IDLE.
- Short frame: vsync after line 0x0C0 during CAPTURE -> err_short=1 and no frame_done. Next full frame -> frame_done.
- Watchdog: WDOG=1000, vsync held low -> err_tmo=1 at cycle 1000 after arm, busy=0.
- Handshake: cmd_req held 10 cycles -> cmd_ack rises cycle 1 and falls 1 cycle after cmd_req drops. A second command during ack is ignored.
- Reset asserted mid-window -> all outputs at reset values; after release, no capture without a new command.
